// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: TinyMIPS instruction-fetch stage. Holds the PC and the IR, assembles
// the IR big-endian from byte-wide memory reads and flags illegal irwrite sequences. Rev 1.0
module fetch_unit #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcen,
  input  logic [1:0]       pcsource,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] aluout,
  input  logic [3:0]       irwrite,
  input  logic [7:0]       memdata,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] imm,
  output logic             ir_valid,
  output logic             irwrite_err
);

  localparam logic [1:0] PC_ALURESULT = 2'b00;
  localparam logic [1:0] PC_ALUOUT    = 2'b01;
  localparam logic [1:0] PC_JUMP      = 2'b10;

  logic [3:0]       byte_seen;
  logic [3:0]       seen_next;
  logic [WIDTH-1:0] pc_next;
  logic             multi_hot;
  logic             seq_err;

  always_comb begin
    pc_next = pc;
    if (pcen) begin
      case (pcsource)
        PC_ALURESULT: pc_next = aluresult;
        PC_ALUOUT:    pc_next = aluout;
        PC_JUMP:      pc_next = {instr[WIDTH-3:0], 2'b00};
        default:      pc_next = pc;
      endcase
    end
  end

  // A lower lane is legal only once the lane above it has been loaded.
  assign multi_hot = (irwrite & (irwrite - 4'd1)) != 4'd0;
  assign seq_err   = |(irwrite[2:0] & ~byte_seen[3:1]);

  always_comb begin
    seen_next = irwrite[3] ? 4'b1000 : byte_seen;
    seen_next = seen_next | {1'b0, irwrite[2:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      byte_seen   <= '0;
      irwrite_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      byte_seen <= seen_next;
      for (int k = 0; k < 4; k++) begin
        if (irwrite[k]) instr[8*k +: 8] <= memdata;
      end
      if (multi_hot || seq_err) irwrite_err <= 1'b1;
    end
  end

  assign ir_valid = (byte_seen == 4'b1111);
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[WIDTH-1:0];

endmodule
`default_nettype wire
